afifo: RTL and testbench
========================

Name: afifo

Overview:
- Single-clock FIFO buffer. Data words are written in at the tail and read out from the head in order.
- Exposes full and empty status.
- Sits between a producer and a consumer in the same clock domain.
- Keeps the AFIFO interface naming (wr_/rd_ sides) so a later dual-clock variant is a drop-in replacement.

Parameters:
- DATA_WIDTH, 32, width of the wdata and rdata words.
- AFIFO_DEEPTH, 8, number of storage entries. Must be a power of two, at least 2. ADDR_W = $clog2(AFIFO_DEEPTH).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wdata  in  DATA_WIDTH  write data, sampled when a write is accepted.
- rd_en  in  1  read request.
- rdata  out  DATA_WIDTH  registered read data.
- wr_full  out  1  FIFO holds AFIFO_DEEPTH entries.
- rd_empty  out  1  FIFO holds 0 entries.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - write and read pointers cleared to 0; rdata cleared to 0.
  - Result: rd_empty=1, wr_full=0.
  - Storage contents are not reset.
  - Reset overrides any concurrent wr_en/rd_en.
- Pointers:
  - wptr and rptr are ADDR_W+1 bits wide. Only the low ADDR_W bits address storage; the MSB is the wrap bit.
  - Pointers increment modulo 2^(ADDR_W+1).
- Flags are combinational from the current pointers:
  - rd_empty = (wptr == rptr).
  - wr_full = (MSBs differ) and (low ADDR_W bits equal).
- Write accept = wr_en & ~wr_full. On accept: mem[wptr[ADDR_W-1:0]] <= wdata; wptr <= wptr+1.
- Read accept = rd_en & ~rd_empty. On accept: rdata <= mem[rptr[ADDR_W-1:0]]; rptr <= rptr+1.
  - Latency: data is visible on rdata the cycle after the accepting edge.
  - rdata holds its value when no read is accepted.
- Write while full: dropped. No pointer change, storage unchanged.
- Read while empty: ignored. rdata holds, rptr unchanged.
- Simultaneous wr_en and rd_en:
  - When neither flag blocks them, both are accepted in the same cycle; occupancy is unchanged.
  - When full: only the read is accepted; the write is dropped, because accept uses the pre-edge wr_full.
  - When empty: only the write is accepted; the read is ignored (no write-to-read bypass).
- Wrap-around: after AFIFO_DEEPTH writes and AFIFO_DEEPTH reads, pointers wrap and ordering is preserved indefinitely.

Optional Feature:
- Macro AFIFO_ERR_FLAGS_EN.
- When defined, two extra output ports (1 bit each):
  - wr_ovf: sticky, set on any write attempt while full.
  - rd_udf: sticky, set on any read attempt while empty.
  - Both cleared only by rst.
- When undefined, these ports and their registers do not exist. Core behaviour is identical either way.

Decomposition:
- Package afifo_pkg holds:
  - default constants AFIFO_DATA_WIDTH_DEF=32 and AFIFO_DEPTH_DEF=8;
  - a helper function returning the pointer width ADDR_W+1.
- One sub-module, afifo_mem: simple dual-port register array.
  - One synchronous write port.
  - One read port with a registered output and a read-enable.
  - Parameterised by DATA_WIDTH and AFIFO_DEEPTH.
- Pointer and flag logic stays in afifo.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release -> rd_empty=1, wr_full=0, rdata=0.
- Single word: write 0xA5A5A5A5 for 1 cycle, then rd_en for 1 cycle -> rdata=0xA5A5A5A5 the cycle after the read; rd_empty=1 afterwards.
- Fill: write 0..7 on consecutive cycles -> wr_full=1 after the 8th write. A 9th write of 0xDEADBEEF is dropped (wr_ovf=1 if AFIFO_ERR_FLAGS_EN).
- Drain: 8 consecutive reads -> rdata sequence 0..7, then rd_empty=1. A further read leaves rdata=7 (rd_udf=1 if enabled).
- Reuse after empty: write 0x12345678, then read -> rdata=0x12345678; pointers have wrapped past depth with no corruption.
- Concurrent: with 3 entries held, assert wr_en and rd_en for 10 cycles -> level stays 3 and output order matches input order. When full, assert both -> one read is accepted and the write is dropped.

Source files
------------

// File: rtl/afifo_pkg.sv
// Shared defaults and pointer-width helper for the afifo block.
package afifo_pkg;

  localparam int unsigned AFIFO_DATA_WIDTH_DEF = 32;
  localparam int unsigned AFIFO_DEPTH_DEF      = 8;

  // Pointers carry one extra wrap bit above the storage address.
  function automatic int unsigned afifo_ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/afifo_mem.sv
// Simple dual-port register array: synchronous write, registered read with enable.
module afifo_mem
  import afifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = AFIFO_DATA_WIDTH_DEF,
  parameter int unsigned AFIFO_DEEPTH = AFIFO_DEPTH_DEF,
  localparam int unsigned ADDR_W      = $clog2(AFIFO_DEEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [AFIFO_DEEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/afifo.sv
// Single-clock FIFO with AFIFO-style wr_/rd_ naming.
// Optional sticky overflow/underflow flags enabled by defining AFIFO_ERR_FLAGS_EN.
module afifo
  import afifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = AFIFO_DATA_WIDTH_DEF,
  parameter int unsigned AFIFO_DEEPTH = AFIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wr_full,
  output logic                  rd_empty
`ifdef AFIFO_ERR_FLAGS_EN
  ,
  output logic                  wr_ovf,
  output logic                  rd_udf
`endif
);

  localparam int unsigned PTR_W  = afifo_ptr_width(AFIFO_DEEPTH);
  localparam int unsigned ADDR_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             wr_accept, rd_accept;

  // Same address with opposite wrap bits means the writer is a full lap ahead.
  assign rd_empty = (wptr_q == rptr_q);
  assign wr_full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                    (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

  assign wr_accept = wr_en && !wr_full;
  assign rd_accept = rd_en && !rd_empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_accept) begin
      wptr_d = wptr_q + PtrOne;
    end
    if (rd_accept) begin
      rptr_d = rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  afifo_mem #(
    .DATA_WIDTH  (DATA_WIDTH),
    .AFIFO_DEEPTH(AFIFO_DEEPTH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_accept),
    .waddr(wptr_q[ADDR_W-1:0]),
    .wdata(wdata),
    .re   (rd_accept),
    .raddr(rptr_q[ADDR_W-1:0]),
    .rdata(rdata)
  );

`ifdef AFIFO_ERR_FLAGS_EN
  logic wr_ovf_q, rd_udf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ovf_q <= 1'b0;
      rd_udf_q <= 1'b0;
    end else begin
      if (wr_en && wr_full) begin
        wr_ovf_q <= 1'b1;
      end
      if (rd_en && rd_empty) begin
        rd_udf_q <= 1'b1;
      end
    end
  end

  assign wr_ovf = wr_ovf_q;
  assign rd_udf = rd_udf_q;
`endif

endmodule

// File: tb/tb_afifo.sv
// Directed self-checking bench for afifo (default depth 8, width 32).
module tb_afifo;

  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic          rd_en;
  logic [DW-1:0] rdata;
  logic          wr_full;
  logic          rd_empty;
`ifdef AFIFO_ERR_FLAGS_EN
  logic          wr_ovf;
  logic          rd_udf;
`endif

  int n_vec;
  int n_err;

  afifo #(
    .DATA_WIDTH  (DW),
    .AFIFO_DEEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wdata   (wdata),
    .rd_en   (rd_en),
    .rdata   (rdata),
    .wr_full (wr_full),
    .rd_empty(rd_empty)
`ifdef AFIFO_ERR_FLAGS_EN
    ,
    .wr_ovf  (wr_ovf),
    .rd_udf  (rd_udf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock with the given request lines, then release them; sampling point is 1ns after edge.
  task automatic cycle(input logic we, input logic re, input logic [DW-1:0] d);
    wr_en = we;
    rd_en = re;
    wdata = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_empty", DW'(rd_empty), 1);
    check("reset_full",  DW'(wr_full),  0);
    check("reset_rdata", rdata, 32'h0);
`ifdef AFIFO_ERR_FLAGS_EN
    check("reset_ovf", DW'(wr_ovf), 0);
    check("reset_udf", DW'(rd_udf), 0);
`endif

    // Single word
    cycle(1'b1, 1'b0, 32'hA5A5_A5A5);
    check("single_not_empty", DW'(rd_empty), 0);
    cycle(1'b0, 1'b1, '0);
    check("single_rdata", rdata, 32'hA5A5_A5A5);
    check("single_empty", DW'(rd_empty), 1);

    // Fill to full, then a dropped write
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, DW'(i));
      check($sformatf("fill_full_%0d", i), DW'(wr_full), DW'(i == 7));
    end
    cycle(1'b1, 1'b0, 32'hDEAD_BEEF);
    check("ovf_still_full", DW'(wr_full), 1);
`ifdef AFIFO_ERR_FLAGS_EN
    check("ovf_flag", DW'(wr_ovf), 1);
`endif

    // Drain in order; the first word proves the dropped write did not land
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, '0);
      check($sformatf("drain_rdata_%0d", i), rdata, DW'(i));
      check($sformatf("drain_empty_%0d", i), DW'(rd_empty), DW'(i == 7));
    end
    cycle(1'b0, 1'b1, '0);
    check("udf_rdata_hold", rdata, 32'h7);
    check("udf_empty", DW'(rd_empty), 1);
`ifdef AFIFO_ERR_FLAGS_EN
    check("udf_flag", DW'(rd_udf), 1);
`endif

    // Reuse after wrap
    cycle(1'b1, 1'b0, 32'h1234_5678);
    cycle(1'b0, 1'b1, '0);
    check("reuse_rdata", rdata, 32'h1234_5678);
    check("reuse_empty", DW'(rd_empty), 1);

    // Concurrent read/write at level 3
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, DW'(100 + i));
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, DW'(103 + i));
      check($sformatf("conc_rdata_%0d", i), rdata, DW'(100 + i));
      check($sformatf("conc_level_%0d", i), DW'({wr_full, rd_empty}), 0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, '0);
      check($sformatf("conc_tail_%0d", i), rdata, DW'(110 + i));
    end
    check("conc_final_empty", DW'(rd_empty), 1);

    // Both requests while full: read accepted, write dropped
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(200 + i));
    check("full_before_both", DW'(wr_full), 1);
    cycle(1'b1, 1'b1, 32'hDEAD_BEEF);
    check("full_both_rdata", rdata, 32'd200);
    check("full_both_notfull", DW'(wr_full), 0);
    for (int i = 1; i < 8; i++) begin
      cycle(1'b0, 1'b1, '0);
      check($sformatf("full_both_drain_%0d", i), rdata, DW'(200 + i));
    end
    check("full_both_empty", DW'(rd_empty), 1);

    // Both requests while empty: write accepted, read ignored (no bypass)
    cycle(1'b1, 1'b1, 32'h0000_0BAD);
    check("empty_both_rdata_hold", rdata, 32'd207);
    check("empty_both_not_empty", DW'(rd_empty), 0);

    // Reset overrides a concurrent write
    rst = 1'b1;
    cycle(1'b1, 1'b0, 32'h5555_5555);
    rst = 1'b0;
    check("rst_override_empty", DW'(rd_empty), 1);
    check("rst_override_rdata", rdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
